tone_sequencer: RTL



---
 rtl/tone_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// Note sequencer feeding DivideClkMN: turns pitch/octave commands into M/N divider
// settings and gates the divider enable for the note length minus an articulation gap.
//
// state | meaning
// IDLE  | waiting for a note command, inReady high
// PLAY  | sounding (toneEn high for pitched notes), counting down the play time
// GAP   | silent articulation gap at the end of the note, noteDone in its last cycle
module tone_sequencer #(
   parameter int WIDTH       = 24,
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_250_000
) (
   input  logic             clkI,
   input  logic             rstN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [3:0]       inPitch,
   input  logic [1:0]       inOct,
   input  logic [3:0]       inDur,
   input  logic             stop,
   output logic             toneEn,
   output logic [WIDTH-1:0] M,
   output logic [WIDTH-1:0] N,
   output logic             busy,
   output logic             noteDone
);

   localparam int CW = $clog2(15 * BEAT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [17:0]      base;
   logic [WIDTH-1:0] m_next;
   logic [CW-1:0]    play_len;
   logic             pitched;
   logic             accept;

   // octave-4 divider periods at 50 MHz, C..B
   always_comb begin
      base = '0;
      case (inPitch)
         4'd1:    base = 18'd191110;
         4'd2:    base = 18'd180388;
         4'd3:    base = 18'd170265;
         4'd4:    base = 18'd160705;
         4'd5:    base = 18'd151685;
         4'd6:    base = 18'd143172;
         4'd7:    base = 18'd135139;
         4'd8:    base = 18'd127551;
         4'd9:    base = 18'd120395;
         4'd10:   base = 18'd113636;
         4'd11:   base = 18'd107259;
         4'd12:   base = 18'd101239;
         default: base = '0;
      endcase
   end

   assign pitched  = (inPitch >= 4'd1) && (inPitch <= 4'd12);
   assign m_next   = WIDTH'(base) >> inOct;
   assign play_len = CW'(inDur) * CW'(BEAT_CYCLES) - CW'(GAP_CYCLES);
   assign inReady  = (state == IDLE) && rstN;
   assign accept   = inValid && inReady;

   always_ff @(posedge clkI) begin
      if (!rstN) begin
         state    <= IDLE;
         cnt      <= '0;
         toneEn   <= 1'b0;
         M        <= '0;
         N        <= '0;
         busy     <= 1'b0;
         noteDone <= 1'b0;
      end else begin
         noteDone <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && inDur != 4'd0) begin
                  state  <= PLAY;
                  cnt    <= play_len;
                  busy   <= 1'b1;
                  toneEn <= pitched;
                  if (pitched) begin
                     M <= m_next;
                     N <= (m_next >> 1) + WIDTH'(1);
                  end
               end
            end
            PLAY: begin
               if (stop) begin
                  state  <= IDLE;
                  toneEn <= 1'b0;
                  busy   <= 1'b0;
               end else if (cnt == CW'(1)) begin
                  state    <= GAP;
                  cnt      <= CW'(GAP_CYCLES);
                  toneEn   <= 1'b0;
                  noteDone <= (GAP_CYCLES == 1);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            GAP: begin
               if (stop || cnt == CW'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt      <= cnt - CW'(1);
                  // registered pulse lands in the final gap cycle
                  noteDone <= (cnt == CW'(2));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
